// File: rtl/dcp_uart_tx_pkg.sv
// Shared definitions for the status-printer UART transmitter: FSM encodings,
// frame geometry and default line settings.
package dcp_uart_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // 8N1: start + 8 data + stop
  localparam int FRAME_BITS   = 10;
  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD     = 115200;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/dcp_tx_fifo.sv
// Synchronous byte FIFO with first-word-fall-through output; decouples the
// printer's bursts from the serial line rate.
module dcp_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Guard here as well so a misbehaving caller can never over/underflow
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/dcp_uart_tx.sv
// 8N1 LSB-first UART transmitter fed by a byte FIFO; frames run back to back
// while the FIFO holds data.
module dcp_uart_tx
  import dcp_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vld_tx,
  input  logic [7:0] d_tx,
  output logic       rdy_tx,
  output logic       txd,
  output logic       busy
);

  localparam int DIV  = baud_div(CLK_FREQ, BAUD);
  localparam int CW   = $clog2(DIV);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [2:0]    IDX_LAST = 3'(FRAME_BITS - 3);

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shift;
  logic            bit_end;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_dout;
  logic [CNTW-1:0] fifo_count;

  assign rdy_tx    = ~fifo_full;
  assign fifo_push = vld_tx & ~fifo_full;
  assign bit_end   = (cnt == CNT_LAST);

  // Pop from IDLE immediately, or at the end of a stop bit to chain frames
  assign fifo_pop  = ~fifo_empty &
                     ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));

  dcp_tx_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (d_tx),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      txd   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            state <= ST_START;
            cnt   <= '0;
            txd   <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state <= ST_DATA;
            cnt   <= '0;
            idx   <= '0;
            txd   <= shift[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state <= ST_STOP;
              txd   <= 1'b1;
            end else begin
              idx <= idx + 3'd1;
              txd <= shift[0];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (fifo_pop) begin
              state <= ST_START;
              txd   <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // shift[0] always holds the next data bit to put on the line
  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      shift <= fifo_dout;
    end else if (bit_end && (state == ST_START || state == ST_DATA)) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  assign busy = (state != ST_IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_dcp_uart_tx.sv
// Bench for dcp_uart_tx at DIV=4: table of single-byte frames checked cycle by
// cycle, a line-decoding scoreboard, and hand-written burst/stall/reset sequences.
module tb_dcp_uart_tx;

  localparam int DIV   = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic [7:0] d;
    logic [9:0] bits;   // bits[0] is the first bit on the line (start)
  } vec_t;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       vld_tx = 1'b0;
  logic [7:0] d_tx   = 8'h00;
  logic       rdy_tx;
  logic       txd;
  logic       busy;

  int checks      = 0;
  int failures    = 0;
  int frames_seen = 0;

  logic [7:0] exp_q[$];
  int         mon_cnt  = -1;
  logic [9:0] mon_bits = '0;
  logic [7:0] mon_exp  = '0;

  vec_t        vecs[6];
  logic [39:0] raw;
  logic [79:0] raw2;
  int          acc;
  int          fr0;
  int          n;
  int          zeros;
  int          busy_hi;
  int          rdy_lo;
  logic        a;
  logic        saw_full;

  always #5 clk = ~clk;

  dcp_uart_tx #(
    .CLK_FREQ   (400),
    .BAUD       (100),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .vld_tx (vld_tx),
    .d_tx   (d_tx),
    .rdy_tx (rdy_tx),
    .txd    (txd),
    .busy   (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] expand(input logic [9:0] b);
    logic [39:0] r;
    logic [9:0]  t;
    r = '0;
    t = b;
    for (int j = 0; j < 10; j++) begin
      r = {{4{t[0]}}, r[39:4]};
      t = t >> 1;
    end
    return r;
  endfunction

  task automatic wait_idle(input int max, input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < max) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) check(name, 64'(busy), 64'd0);
  endtask

  // Scoreboard producer: every accepted byte is expected on the line in order
  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else if (vld_tx && rdy_tx) exp_q.push_back(d_tx);
  end

  // Scoreboard consumer: decode frames from txd, sampling mid-bit
  always @(negedge clk) begin
    if (rst) begin
      mon_cnt = -1;
    end else begin
      if (mon_cnt < 0 && txd == 1'b0) mon_cnt = 0;
      if (mon_cnt >= 0) begin
        if (mon_cnt % DIV == DIV / 2) mon_bits = {txd, mon_bits[9:1]};
        mon_cnt++;
        if (mon_cnt == 10 * DIV) begin
          frames_seen++;
          mon_cnt = -1;
          if (exp_q.size() == 0) begin
            check("sb_pending_bytes", 64'(exp_q.size()), 64'd1);
          end else begin
            mon_exp = exp_q.pop_front();
            check("sb_frame", 64'(mon_bits), 64'({1'b1, mon_exp, 1'b0}));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{d: 8'h55, bits: 10'h2AA};
    vecs[1] = '{d: 8'hA5, bits: 10'h34A};
    vecs[2] = '{d: 8'h3C, bits: 10'h278};
    vecs[3] = '{d: 8'h00, bits: 10'h200};
    vecs[4] = '{d: 8'hFF, bits: 10'h3FE};
    vecs[5] = '{d: 8'h81, bits: 10'h302};

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_txd", 64'(txd), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", 64'(rdy_tx), 64'd1);
    check("post_rst_txd", 64'(txd), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);

    // Single-byte frames, cycle-exact
    foreach (vecs[i]) begin
      step();
      vld_tx = 1'b1;
      d_tx   = vecs[i].d;
      step();
      vld_tx = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_pre_start_txd", i), 64'(txd), 64'd1);
      for (int j = 0; j < 40; j++) begin
        @(negedge clk);
        raw = {txd, raw[39:1]};
        if (j == 20) check($sformatf("vec%0d_busy_mid", i), 64'(busy), 64'd1);
      end
      check($sformatf("vec%0d_frame", i), 64'(raw), 64'(expand(vecs[i].bits)));
      @(negedge clk);
      check($sformatf("vec%0d_end_txd", i), 64'(txd), 64'd1);
      check($sformatf("vec%0d_end_busy", i), 64'(busy), 64'd0);
    end

    // Back-to-back frames with no idle gap
    step();
    vld_tx = 1'b1;
    d_tx   = 8'hA5;
    step();
    d_tx   = 8'h3C;
    step();
    vld_tx = 1'b0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      raw2 = {txd, raw2[79:1]};
    end
    check("b2b_first", 64'(raw2[39:0]), 64'(expand(10'h34A)));
    check("b2b_second", 64'(raw2[79:40]), 64'(expand(10'h278)));
    wait_idle(200, "b2b_idle_timeout");

    // Burst with vld_tx held from reset
    fr0 = frames_seen;
    step();
    rst    = 1'b1;
    vld_tx = 1'b1;
    d_tx   = 8'h00;
    step();
    step();
    rst = 1'b0;
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      a = rdy_tx & vld_tx;
      step();
      if (a) begin
        acc++;
        d_tx = 8'(acc);
      end
    end
    @(negedge clk);
    check("burst_accepted_initial", 64'(acc), 64'd17);
    check("burst_rdy_full", 64'(rdy_tx), 64'd0);
    n = 0;
    while (acc < 20 && n < 400) begin
      @(negedge clk);
      a = rdy_tx & vld_tx;
      step();
      n++;
      if (a) begin
        acc++;
        d_tx = 8'(acc);
      end
    end
    vld_tx = 1'b0;
    check("burst_accepted_total", 64'(acc), 64'd20);
    wait_idle(1200, "burst_idle_timeout");
    check("burst_frames", 64'(frames_seen - fr0), 64'd20);

    // Stall hold: byte presented while full goes out exactly once
    fr0      = frames_seen;
    acc      = 0;
    saw_full = 1'b0;
    step();
    vld_tx = 1'b1;
    d_tx   = 8'h40;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!rdy_tx) begin
        saw_full = 1'b1;
        break;
      end
      step();
      acc++;
      d_tx = d_tx + 8'd1;
      n++;
    end
    check("stall_full_seen", 64'(saw_full), 64'd1);
    d_tx = 8'h7E;
    n = 0;
    a = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      a = rdy_tx;
      step();
      n++;
      if (a) break;
    end
    vld_tx = 1'b0;
    check("stall_hold_accepted", 64'(a), 64'd1);
    wait_idle(1200, "stall_idle_timeout");
    check("stall_frames", 64'(frames_seen - fr0), 64'(acc + 1));

    // Reset in the middle of a 0xFF frame with three bytes queued
    fr0 = frames_seen;
    step();
    vld_tx = 1'b1;
    d_tx   = 8'hFF;
    step();
    d_tx = 8'h01;
    step();
    d_tx = 8'h02;
    step();
    d_tx = 8'h03;
    step();
    vld_tx = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_txd", 64'(txd), 64'd1);
    check("midrst_rdy", 64'(rdy_tx), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    step();
    rst     = 1'b0;
    zeros   = 0;
    busy_hi = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (txd !== 1'b1) zeros++;
      if (busy !== 1'b0) busy_hi++;
    end
    check("midrst_no_frames_txd", 64'(zeros), 64'd0);
    check("midrst_no_frames_busy", 64'(busy_hi), 64'd0);
    check("midrst_frame_count", 64'(frames_seen - fr0), 64'd0);

    // Idle with d_tx toggling and vld_tx low
    zeros   = 0;
    busy_hi = 0;
    rdy_lo  = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      d_tx = ~d_tx;
      @(negedge clk);
      if (txd !== 1'b1) zeros++;
      if (busy !== 1'b0) busy_hi++;
      if (rdy_tx !== 1'b1) rdy_lo++;
    end
    check("idle_txd_high", 64'(zeros), 64'd0);
    check("idle_busy_low", 64'(busy_hi), 64'd0);
    check("idle_rdy_high", 64'(rdy_lo), 64'd0);

    check("sb_queue_drained", 64'(exp_q.size()), 64'd0);
    check("sb_monitor_idle", 64'(mon_cnt), 64'(-1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
